// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// MULT/MULTU/DIV/DIVU compute into temp registers when accepted and commit
// them to HI/LO after MUL_CYCLES/DIV_CYCLES. MTHI/MTLO write in one cycle.
// A divide by zero still occupies the unit but leaves HI/LO untouched.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU
// (ops 7-10), which accumulate into {hi,lo}. Without it those ops are NOPs.
module mdu #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_temp_hi;
    logic [31:0]        r_temp_lo;
    logic [3:0]         r_op;
    logic [31:0]        r_rt;
    logic [CNT_W-1:0]   r_count;

    // Products: both flavours are formed from 64-bit extended operands
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};
    assign w_prod_s = $unsigned($signed({{32{rs_val[31]}}, rs_val}) *
                                $signed({{32{rt_val[31]}}, rt_val}));

    // Unsigned divide; a zero divisor is replaced by 1 so the datapath never
    // sees x/0 (the result is discarded at commit anyway).
    logic [31:0] w_divu_by;
    logic [31:0] w_quo_u;
    logic [31:0] w_rem_u;
    assign w_divu_by = (rt_val == 32'd0) ? 32'd1 : rt_val;
    assign w_quo_u   = rs_val / w_divu_by;
    assign w_rem_u   = rs_val % w_divu_by;

    // Signed divide via magnitudes: quotient negated when signs differ,
    // remainder takes the dividend's sign. 0x80000000 / -1 wraps naturally
    // to quotient 0x80000000, remainder 0.
    logic        w_sa;
    logic        w_sb;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_mag_b_nz;
    logic [31:0] w_quo_mag;
    logic [31:0] w_rem_mag;
    logic [31:0] w_quo_s;
    logic [31:0] w_rem_s;
    assign w_sa       = rs_val[31];
    assign w_sb       = rt_val[31];
    assign w_mag_a    = w_sa ? (~rs_val + 32'd1) : rs_val;
    assign w_mag_b    = w_sb ? (~rt_val + 32'd1) : rt_val;
    assign w_mag_b_nz = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
    assign w_quo_mag  = w_mag_a / w_mag_b_nz;
    assign w_rem_mag  = w_mag_a % w_mag_b_nz;
    assign w_quo_s    = (w_sa ^ w_sb) ? (~w_quo_mag + 32'd1) : w_quo_mag;
    assign w_rem_s    = w_sa ? (~w_rem_mag + 32'd1) : w_rem_mag;

`ifdef MDU_MADD_EN
    // Accumulate ops read {hi,lo} as it stands at the accepting edge
    logic [63:0] w_acc;
    assign w_acc = {r_hi, r_lo};
`endif

    logic             w_is_multi;
    logic             w_is_mthi;
    logic             w_is_mtlo;
    logic [63:0]      w_result;
    logic [CNT_W-1:0] w_latency;
    logic             w_skip_commit;

    // Decode the incoming op into its class, result and latency
    always_comb begin
        w_is_multi = 1'b0;
        w_is_mthi  = 1'b0;
        w_is_mtlo  = 1'b0;
        w_result   = 64'd0;
        w_latency  = CNT_W'(MUL_CYCLES);
        case (op)
            OP_MULT: begin
                w_is_multi = 1'b1;
                w_result   = w_prod_s;
            end
            OP_MULTU: begin
                w_is_multi = 1'b1;
                w_result   = w_prod_u;
            end
            OP_DIV: begin
                w_is_multi = 1'b1;
                w_result   = {w_rem_s, w_quo_s};
                w_latency  = CNT_W'(DIV_CYCLES);
            end
            OP_DIVU: begin
                w_is_multi = 1'b1;
                w_result   = {w_rem_u, w_quo_u};
                w_latency  = CNT_W'(DIV_CYCLES);
            end
            OP_MTHI: w_is_mthi = 1'b1;
            OP_MTLO: w_is_mtlo = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD: begin
                w_is_multi = 1'b1;
                w_result   = w_acc + w_prod_s;
            end
            OP_MADDU: begin
                w_is_multi = 1'b1;
                w_result   = w_acc + w_prod_u;
            end
            OP_MSUB: begin
                w_is_multi = 1'b1;
                w_result   = w_acc - w_prod_s;
            end
            OP_MSUBU: begin
                w_is_multi = 1'b1;
                w_result   = w_acc - w_prod_u;
            end
`endif
            default: ;
        endcase
    end

    // A divide whose latched divisor was zero completes without writing
    assign w_skip_commit = ((r_op == OP_DIV) || (r_op == OP_DIVU)) && (r_rt == 32'd0);

    // IDLE accepts ops; RUN counts down and commits temp results on the last edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_temp_hi <= 32'd0;
            r_temp_lo <= 32'd0;
            r_op      <= 4'd0;
            r_rt      <= 32'd0;
            r_count   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid) begin
                        if (w_is_mthi) r_hi <= rs_val;
                        if (w_is_mtlo) r_lo <= rs_val;
                        if (w_is_multi) begin
                            r_temp_hi <= w_result[63:32];
                            r_temp_lo <= w_result[31:0];
                            r_op      <= op;
                            r_rt      <= rt_val;
                            r_count   <= w_latency;
                            r_busy    <= 1'b1;
                            r_state   <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (r_count == CNT_W'(1)) begin
                        if (!w_skip_commit) begin
                            r_hi <= r_temp_hi;
                            r_lo <= r_temp_lo;
                        end
                        r_count <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_count <= r_count - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign start = valid && w_is_multi;
    assign busy  = r_busy;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu. Expected HI/LO/latency are pushed when an
// op is issued and popped when the unit goes idle again.
module tb_mdu;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t scoreboard[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk    (clk),
        .reset  (reset),
        .valid  (valid),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .start  (start),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    // Reference model working on 64-bit integers
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] ch, input logic [31:0] cl);
        exp_t   e;
        longint sa, sbv, q, r;
        logic [63:0] p;
        e.hi = ch;
        e.lo = cl;
        e.cycles = 0;
        case (o)
            4'd1: begin p = longint'($signed(a)) * longint'($signed(b)); e.hi = p[63:32]; e.lo = p[31:0]; e.cycles = MUL_N; end
            4'd2: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; e.cycles = MUL_N; end
            4'd3: begin
                e.cycles = DIV_N;
                if (b != 32'd0) begin
                    sa = longint'($signed(a)); sbv = longint'($signed(b));
                    q = sa / sbv; r = sa % sbv;
                    e.lo = q[31:0]; e.hi = r[31:0];
                end
            end
            4'd4: begin
                e.cycles = DIV_N;
                if (b != 32'd0) begin e.lo = a / b; e.hi = a % b; end
            end
            4'd5: e.hi = a;
            4'd6: e.lo = a;
`ifdef MDU_MADD_EN
            4'd7: begin p = {ch, cl} + 64'(longint'($signed(a)) * longint'($signed(b))); e.hi = p[63:32]; e.lo = p[31:0]; e.cycles = MUL_N; end
            4'd8: begin p = {ch, cl} + {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; e.cycles = MUL_N; end
            4'd9: begin p = {ch, cl} - 64'(longint'($signed(a)) * longint'($signed(b))); e.hi = p[63:32]; e.lo = p[31:0]; e.cycles = MUL_N; end
            4'd10: begin p = {ch, cl} - {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; e.cycles = MUL_N; end
`endif
            default: ;
        endcase
        return e;
    endfunction

    // Issue one op and wait (bounded) until the unit is idle again
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cycles, output logic start_seen, output logic held);
        logic [31:0] h0, l0;
        @(negedge clk);
        valid = 1'b1; op = o; rs_val = a; rt_val = b;
        #1;
        start_seen = start;
        h0 = hi; l0 = lo; held = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; op = 4'd0;
        cycles = 0;
        while (busy && cycles < 200) begin
            if (hi !== h0 || lo !== l0) held = 1'b0;
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic test_reset;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
        n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", start); end
        $display("reset: busy=%b hi=%h lo=%h", busy, hi, lo);
    endtask

    // Directed spec vectors plus random ones, all through the scoreboard
    task automatic test_arith;
        logic [3:0]  ops[12];
        logic [31:0] as[12];
        logic [31:0] bs[12];
        exp_t e;
        int c;
        logic s, h;
        ops[0] = 4'd5; as[0] = 32'h0000_5555; bs[0] = 32'd0;
        ops[1] = 4'd6; as[1] = 32'h0000_6666; bs[1] = 32'd0;
        ops[2] = 4'd1; as[2] = 32'hFFFF_FFFE; bs[2] = 32'd3;
        ops[3] = 4'd3; as[3] = 32'd7;         bs[3] = 32'hFFFF_FFFE;
        ops[4] = 4'd4; as[4] = 32'hFFFF_FFFF; bs[4] = 32'd2;
        ops[5] = 4'd3; as[5] = 32'h8000_0000; bs[5] = 32'hFFFF_FFFF;
        for (int i = 6; i < 12; i++) begin
            ops[i] = 4'($urandom_range(1, 4));
            as[i]  = $urandom;
            bs[i]  = (i == 9) ? 32'd0 : $urandom;
        end
        for (int i = 0; i < 12; i++) begin
            scoreboard.push_back(model(ops[i], as[i], bs[i], m_hi, m_lo));
            run_op(ops[i], as[i], bs[i], c, s, h);
            e = scoreboard.pop_front();
            m_hi = e.hi; m_lo = e.lo;
            $display("arith op=%0d a=%h b=%h -> hi=%h lo=%h cycles=%0d", ops[i], as[i], bs[i], hi, lo, c);
            n_checks++; if (hi !== e.hi) begin n_fail++; $display("FAIL arith_hi[%0d]: got %h want %h", i, hi, e.hi); end
            n_checks++; if (lo !== e.lo) begin n_fail++; $display("FAIL arith_lo[%0d]: got %h want %h", i, lo, e.lo); end
            n_checks++; if (c != e.cycles) begin n_fail++; $display("FAIL arith_cycles[%0d]: got %0d want %0d", i, c, e.cycles); end
            n_checks++; if (s !== (e.cycles != 0)) begin n_fail++; $display("FAIL arith_start[%0d]: got %b want %b", i, s, e.cycles != 0); end
            n_checks++; if (h !== 1'b1) begin n_fail++; $display("FAIL arith_hold[%0d]: hi/lo changed during run", i); end
        end
    endtask

    // Spec constants checked literally, independent of the model
    task automatic test_spec_constants;
        int c;
        logic s, h;
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, c, s, h);
        $display("mult_const: hi=%h lo=%h", hi, lo);
        n_checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin n_fail++; $display("FAIL mult_const: got %h%h want ffffffff fffffffa", hi, lo); end
        run_op(4'd3, 32'd7, 32'hFFFF_FFFE, c, s, h);
        $display("div_const: hi=%h lo=%h", hi, lo);
        n_checks++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD) begin n_fail++; $display("FAIL div_const: got %h%h want 00000001 fffffffd", hi, lo); end
        run_op(4'd4, 32'hFFFF_FFFF, 32'd2, c, s, h);
        $display("divu_const: hi=%h lo=%h", hi, lo);
        n_checks++; if ({hi, lo} !== 64'h0000_0001_7FFF_FFFF) begin n_fail++; $display("FAIL divu_const: got %h%h want 00000001 7fffffff", hi, lo); end
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, c, s, h);
        $display("div_ovf_const: hi=%h lo=%h", hi, lo);
        n_checks++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin n_fail++; $display("FAIL div_ovf_const: got %h%h want 00000000 80000000", hi, lo); end
        m_hi = 32'd0; m_lo = 32'h8000_0000;
    endtask

    task automatic test_div_zero;
        int c;
        logic s, h;
        run_op(4'd5, 32'h11, 32'd0, c, s, h);
        run_op(4'd6, 32'h22, 32'd0, c, s, h);
        scoreboard.push_back('{hi: 32'h11, lo: 32'h22, cycles: DIV_N});
        run_op(4'd3, 32'd5, 32'd0, c, s, h);
        begin
            exp_t e;
            e = scoreboard.pop_front();
            $display("div_zero: hi=%h lo=%h cycles=%0d", hi, lo, c);
            n_checks++; if (c != e.cycles) begin n_fail++; $display("FAIL divzero_cycles: got %0d want %0d", c, e.cycles); end
            n_checks++; if (hi !== e.hi || lo !== e.lo) begin n_fail++; $display("FAIL divzero_hilo: got %h/%h want %h/%h", hi, lo, e.hi, e.lo); end
        end
        m_hi = 32'h11; m_lo = 32'h22;
    endtask

    task automatic test_mtlo_while_busy;
        int c;
        logic s, h;
        exp_t e;
        scoreboard.push_back('{hi: 32'd0, lo: 32'd6, cycles: MUL_N});
        @(negedge clk);
        valid = 1'b1; op = 4'd1; rs_val = 32'd2; rt_val = 32'd3;
        @(posedge clk); #1;
        valid = 1'b0; op = 4'd0;
        @(negedge clk);
        valid = 1'b1; op = 4'd6; rs_val = 32'h0000_ABCD;
        @(posedge clk); #1;
        valid = 1'b0; op = 4'd0;
        c = 1;
        while (busy && c < 200) begin @(posedge clk); #1; c++; end
        e = scoreboard.pop_front();
        $display("mtlo_busy: hi=%h lo=%h cycles=%0d", hi, lo, c);
        n_checks++; if (c != e.cycles) begin n_fail++; $display("FAIL mtlo_busy_cycles: got %0d want %0d", c, e.cycles); end
        n_checks++; if (lo !== e.lo || hi !== e.hi) begin n_fail++; $display("FAIL mtlo_busy_ignored: got %h/%h want %h/%h", hi, lo, e.hi, e.lo); end
        run_op(4'd6, 32'h0000_ABCD, 32'd0, c, s, h);
        $display("mtlo_after: hi=%h lo=%h busy=%b", hi, lo, busy);
        n_checks++; if (lo !== 32'h0000_ABCD) begin n_fail++; $display("FAIL mtlo_after_lo: got %h want 0000abcd", lo); end
        n_checks++; if (c != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_after_busy: got cycles %0d busy %b want 0 0", c, busy); end
        n_checks++; if (s !== 1'b0) begin n_fail++; $display("FAIL mtlo_start: got %b want 0", s); end
        m_hi = 32'd0; m_lo = 32'h0000_ABCD;
    endtask

    // Second op issued on the edge right after busy falls
    task automatic test_back_to_back;
        int c;
        logic s, h;
        exp_t e;
        scoreboard.push_back(model(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, m_hi, m_lo));
        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c, s, h);
        e = scoreboard.pop_front();
        m_hi = e.hi; m_lo = e.lo;
        n_checks++; if ({hi, lo} !== {e.hi, e.lo}) begin n_fail++; $display("FAIL b2b_first: got %h%h want %h%h", hi, lo, e.hi, e.lo); end
        scoreboard.push_back(model(4'd4, 32'd100, 32'd7, m_hi, m_lo));
        run_op(4'd4, 32'd100, 32'd7, c, s, h);
        e = scoreboard.pop_front();
        m_hi = e.hi; m_lo = e.lo;
        $display("b2b: hi=%h lo=%h cycles=%0d", hi, lo, c);
        n_checks++; if ({hi, lo} !== 64'h0000_0002_0000_000E) begin n_fail++; $display("FAIL b2b_second: got %h%h want 00000002 0000000e", hi, lo); end
        n_checks++; if (c != e.cycles) begin n_fail++; $display("FAIL b2b_cycles: got %0d want %0d", c, e.cycles); end
    endtask

    task automatic test_reset_midrun;
        int c;
        logic s, h;
        run_op(4'd5, 32'h1234, 32'd0, c, s, h);
        @(negedge clk);
        valid = 1'b1; op = 4'd1; rs_val = 32'd2; rt_val = 32'd3;
        @(posedge clk); #1;
        valid = 1'b0; op = 4'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        $display("reset_midrun: busy=%b hi=%h lo=%h", busy, hi, lo);
        n_checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL reset_async: got busy %b hi %h lo %h want 0 0 0", busy, hi, lo); end
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        $display("reset_after: busy=%b hi=%h lo=%h", busy, hi, lo);
        n_checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL reset_no_write: got busy %b hi %h lo %h want 0 0 0", busy, hi, lo); end
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_madd;
        int c;
        logic s, h;
        run_op(4'd5, 32'd0, 32'd0, c, s, h);
        run_op(4'd6, 32'd1, 32'd0, c, s, h);
        m_hi = 32'd0; m_lo = 32'd1;
`ifdef MDU_MADD_EN
        begin
            exp_t e;
            scoreboard.push_back('{hi: 32'd0, lo: 32'd7, cycles: MUL_N});
            run_op(4'd7, 32'd2, 32'd3, c, s, h);
            e = scoreboard.pop_front();
            $display("madd: hi=%h lo=%h cycles=%0d", hi, lo, c);
            n_checks++; if ({hi, lo} !== {e.hi, e.lo}) begin n_fail++; $display("FAIL madd_result: got %h%h want %h%h", hi, lo, e.hi, e.lo); end
            n_checks++; if (c != e.cycles || s !== 1'b1) begin n_fail++; $display("FAIL madd_timing: got cycles %0d start %b want %0d 1", c, s, e.cycles); end
            scoreboard.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFF, cycles: MUL_N});
            run_op(4'd10, 32'd1, 32'd8, c, s, h);
            e = scoreboard.pop_front();
            $display("msubu: hi=%h lo=%h cycles=%0d", hi, lo, c);
            n_checks++; if ({hi, lo} !== {e.hi, e.lo}) begin n_fail++; $display("FAIL msubu_result: got %h%h want %h%h", hi, lo, e.hi, e.lo); end
        end
`else
        run_op(4'd7, 32'd2, 32'd3, c, s, h);
        $display("madd_disabled: hi=%h lo=%h start=%b cycles=%0d", hi, lo, s, c);
        n_checks++; if (s !== 1'b0 || c != 0) begin n_fail++; $display("FAIL madd_nop_start: got start %b cycles %0d want 0 0", s, c); end
        n_checks++; if (hi !== 32'd0 || lo !== 32'd1) begin n_fail++; $display("FAIL madd_nop_hilo: got %h/%h want 00000000/00000001", hi, lo); end
`endif
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; op = 4'd0; rs_val = 32'd0; rt_val = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_arith();
        test_spec_constants();
        test_div_zero();
        test_mtlo_while_busy();
        test_back_to_back();
        test_reset_midrun();
        test_madd();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the register file in the execute stage.
- Consumes the two GRF read values (rs, rt) and services MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Exposes HI/LO for MFHI/MFLO, and a busy flag the stall unit uses to hold later MDU instructions.

Parameters:
- MUL_CYCLES, 5, cycles busy stays high for multiply ops (min 1).
- DIV_CYCLES, 10, cycles busy stays high for divide ops (min 1).

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- valid  input  1  op is a real issued instruction this cycle
- op  input  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11-15 NOP
- rs_val  input  32  operand A (GRF RD1 after forwarding)
- rt_val  input  32  operand B (GRF RD2 after forwarding)
- start  output  1  combinational: valid && op is a multi-cycle op (1-4, or 7-10 when enabled)
- busy  output  1  registered: a multi-cycle op is in progress
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (async, any time, including mid-operation):
  - busy=0, hi=0, lo=0, counter=0.
  - Pending operation discarded; no result is ever written from it.
- Acceptance:
  - An op is accepted only on a clk edge where valid=1 and busy=0.
  - While busy=1 every op is ignored. The stall unit guarantees none arrive, and a bench must not assume any effect if one does.
- MTHI/MTLO:
  - hi<=rs_val (resp. lo<=rs_val) at the accepting edge.
  - Single cycle; busy stays 0.
- Multi-cycle ops:
  - At the accepting edge, latch rs_val, rt_val and op internally.
  - Compute the result into internal temp_hi/temp_lo at that same edge.
  - Load counter with MUL_CYCLES or DIV_CYCLES; busy<=1.
- States: IDLE (busy=0), RUN (busy=1).
  - RUN: counter decrements each edge.
  - Edge where counter==1: hi<=temp_hi, lo<=temp_lo, busy<=0, return to IDLE.
  - Result visible on hi/lo exactly N cycles after the accepting edge (N = MUL_CYCLES or DIV_CYCLES).
  - hi/lo hold old values throughout RUN.
- Stall interface: stall unit must treat (start || busy) as busy. This covers the acceptance cycle, where start=1 and busy is still 0.
- Arithmetic:
  - MULT: {hi,lo}=signed 64-bit product.
  - MULTU: {hi,lo}=unsigned 64-bit product.
  - DIV: lo=signed quotient truncated toward zero; hi=remainder, sign follows dividend.
  - DIVU: unsigned quotient/remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (rt_val==0):
  - busy still runs DIV_CYCLES.
  - hi/lo unchanged at completion.
- Back-to-back: a new op may be accepted on the edge after busy falls. It cannot be accepted on the completing edge itself, since busy=1 then.
- No forwarding of temp results; MFHI/MFLO during RUN are stalled externally.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - op 7/8 (MADD/MADDU): {hi,lo}<={hi,lo}+product, signed/unsigned.
  - op 9/10 (MSUB/MSUBU): {hi,lo}<={hi,lo}-product, signed/unsigned.
  - The current {hi,lo} value is sampled at the accepting edge.
  - 64-bit wrap-around; latency MUL_CYCLES.
  - start asserts for these ops.
- Undefined: op 7-10 are NOP (start=0, no state change).

Test Plan:
- Reset mid-run: MULT rs=2, rt=3 accepted, assert reset after 2 cycles -> busy=0, hi=0, lo=0 immediately; no write later.
- MULT rs=0xFFFFFFFE, rt=3 -> busy 1 for 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA after 5th edge; old hi/lo held until then.
- DIV rs=7, rt=0xFFFFFFFE -> after 10 cycles lo=0xFFFFFFFD, hi=1.
- DIVU rs=0xFFFFFFFF, rt=2 -> lo=0x7FFFFFFF, hi=1.
- DIV by zero: hi=0x11, lo=0x22 preset via MTHI/MTLO, DIV rs=5, rt=0 -> busy 10 cycles; hi/lo still 0x11/0x22.
- MTLO rs=0xABCD during busy -> ignored. After completion MTLO rs=0xABCD -> lo=0xABCD next edge, busy stays 0. With MDU_MADD_EN: hi=0, lo=1, MADD 2x3 -> lo=7.
